// File: rtl/dem_nguoc_hen_gio.sv
// ============================================================================
// Module   : dem_nguoc_hen_gio
// Brief    : BCD mm:ss countdown timer on the 1 Hz tick. Set, run, pause,
//            done states. Optional buzzer timer under COUNTDOWN_BEEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dem_nguoc_hen_gio #(
    parameter logic [7:0]  DEFAULT_PHUT = 8'h05,
    parameter logic [7:0]  DEFAULT_GIAY = 8'h00,
    parameter int unsigned BEEP_SECS    = 10
) (
    input  logic       clk_1Hz,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_start,
    input  logic       btn_clr,
    input  logic       set_sel,
    output logic [7:0] phut,
    output logic [7:0] giay,
    output logic       running,
    output logic       done,
    output logic       beep
);

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_n;
    logic [7:0] r_phut;
    logic [7:0] r_giay;
    logic [7:0] w_phut_n;
    logic [7:0] w_giay_n;
    logic [7:0] r_preset_phut;
    logic [7:0] r_preset_giay;
    logic [7:0] w_preset_phut_n;
    logic [7:0] w_preset_giay_n;
    logic       r_start_q;
    logic       w_start_edge;
    logic       r_running;
    logic       r_done;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h59)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00)
            return 8'h59;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign w_start_edge = r_start_q & ~btn_start;

    always_comb begin
        w_state_n       = r_state;
        w_phut_n        = r_phut;
        w_giay_n        = r_giay;
        w_preset_phut_n = r_preset_phut;
        w_preset_giay_n = r_preset_giay;
        if (!btn_clr) begin
            w_state_n = ST_SET;
            w_phut_n  = r_preset_phut;
            w_giay_n  = r_preset_giay;
        end else begin
            case (r_state)
                ST_SET: begin
                    // A start edge consumes the tick even when ignored at 00:00
                    if (w_start_edge) begin
                        if ({r_phut, r_giay} != 16'h0000) begin
                            w_preset_phut_n = r_phut;
                            w_preset_giay_n = r_giay;
                            w_state_n       = ST_RUN;
                        end
                    end else if (!btn_up) begin
                        if (set_sel) w_phut_n = bcd_inc(r_phut);
                        else         w_giay_n = bcd_inc(r_giay);
                    end else if (!btn_down) begin
                        if (set_sel) w_phut_n = bcd_dec(r_phut);
                        else         w_giay_n = bcd_dec(r_giay);
                    end
                end
                ST_RUN: begin
                    if (w_start_edge) begin
                        w_state_n = ST_PAUSE;
                    end else if ({r_phut, r_giay} <= 16'h0001) begin
                        w_phut_n  = 8'h00;
                        w_giay_n  = 8'h00;
                        w_state_n = ST_DONE;
                    end else if (r_giay != 8'h00) begin
                        w_giay_n = bcd_dec(r_giay);
                    end else begin
                        w_giay_n = 8'h59;
                        w_phut_n = bcd_dec(r_phut);
                    end
                end
                ST_PAUSE: begin
                    if (w_start_edge)
                        w_state_n = ST_RUN;
                end
                ST_DONE: begin
                    if (w_start_edge) begin
                        w_state_n = ST_SET;
                        w_phut_n  = r_preset_phut;
                        w_giay_n  = r_preset_giay;
                    end
                end
                default: w_state_n = ST_SET;
            endcase
        end
    end

    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_SET;
            r_phut        <= DEFAULT_PHUT;
            r_giay        <= DEFAULT_GIAY;
            r_preset_phut <= DEFAULT_PHUT;
            r_preset_giay <= DEFAULT_GIAY;
            r_start_q     <= 1'b1;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_phut        <= w_phut_n;
            r_giay        <= w_giay_n;
            r_preset_phut <= w_preset_phut_n;
            r_preset_giay <= w_preset_giay_n;
            r_start_q     <= btn_start;
            r_running     <= (w_state_n == ST_RUN);
            r_done        <= (w_state_n == ST_DONE);
        end
    end

`ifdef COUNTDOWN_BEEP_EN
    localparam logic [7:0] c_beep_load = BEEP_SECS[7:0];

    logic [7:0] r_beep_cnt;
    logic       r_beep;

    // Counter is armed on DONE entry and only runs while DONE persists
    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            r_beep_cnt <= 8'd0;
            r_beep     <= 1'b0;
        end else if (w_state_n == ST_DONE && r_state != ST_DONE) begin
            r_beep_cnt <= c_beep_load;
            r_beep     <= 1'b1;
        end else if (w_state_n == ST_DONE) begin
            if (r_beep_cnt != 8'd0)
                r_beep_cnt <= r_beep_cnt - 8'd1;
            r_beep <= (r_beep_cnt > 8'd1);
        end else begin
            r_beep_cnt <= 8'd0;
            r_beep     <= 1'b0;
        end
    end

    assign beep = r_beep;
`else
    assign beep = 1'b0;
`endif

    assign phut    = r_phut;
    assign giay    = r_giay;
    assign running = r_running;
    assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_dem_nguoc_hen_gio.sv
// ============================================================================
// Module   : tb_dem_nguoc_hen_gio
// Brief    : Directed bench for dem_nguoc_hen_gio with an expected-value queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dem_nguoc_hen_gio;

`ifdef COUNTDOWN_BEEP_EN
    localparam bit c_beep_on = 1'b1;
`else
    localparam bit c_beep_on = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] p;
        logic [7:0] g;
        logic       r;
        logic       d;
        logic       b;
    } exp_t;

    logic       clk_1Hz = 1'b0;
    logic       rst_n;
    logic       btn_up, btn_down, btn_start, btn_clr, set_sel;
    logic [7:0] phut, giay;
    logic       running, done, beep;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    dem_nguoc_hen_gio dut (
        .clk_1Hz   (clk_1Hz),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_start (btn_start),
        .btn_clr   (btn_clr),
        .set_sel   (set_sel),
        .phut      (phut),
        .giay      (giay),
        .running   (running),
        .done      (done),
        .beep      (beep)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        n_assert++;
        assert (phut === e.p) else begin
            n_fail++; $error("FAIL %s phut: got %h expected %h", tag, phut, e.p);
        end
        n_assert++;
        assert (giay === e.g) else begin
            n_fail++; $error("FAIL %s giay: got %h expected %h", tag, giay, e.g);
        end
        n_assert++;
        assert (running === e.r) else begin
            n_fail++; $error("FAIL %s running: got %b expected %b", tag, running, e.r);
        end
        n_assert++;
        assert (done === e.d) else begin
            n_fail++; $error("FAIL %s done: got %b expected %b", tag, done, e.d);
        end
        n_assert++;
        assert (beep === e.b) else begin
            n_fail++; $error("FAIL %s beep: got %b expected %b", tag, beep, e.b);
        end
    endtask

    // Drive buttons (active-low), queue the expectation, sample after the edge
    task automatic step(input logic up, input logic dn, input logic st, input logic clr,
                        input logic [7:0] ep, input logic [7:0] eg,
                        input logic er, input logic ed, input logic eb, input string tag);
        btn_up    = up;
        btn_down  = dn;
        btn_start = st;
        btn_clr   = clr;
        sb.push_back('{p: ep, g: eg, r: er, d: ed, b: eb & c_beep_on});
        @(posedge clk_1Hz);
        #1;
        check_out(tag);
    endtask

    initial begin
        logic [7:0] phut_seq [6];
        logic [7:0] g;
        phut_seq = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h59};

        rst_n = 1'b0; btn_up = 1'b1; btn_down = 1'b1; btn_start = 1'b1;
        btn_clr = 1'b1; set_sel = 1'b0;
        repeat (2) @(posedge clk_1Hz);
        #1 rst_n = 1'b1;
        sb.push_back('{p: 8'h05, g: 8'h00, r: 1'b0, d: 1'b0, b: 1'b0});
        check_out("reset");

        set_sel = 1'b0;
        step(0, 0, 1, 1, 8'h05, 8'h01, 0, 0, 0, "up_down_both");
        step(1, 0, 1, 1, 8'h05, 8'h00, 0, 0, 0, "giay_dec");
        step(1, 0, 1, 1, 8'h05, 8'h59, 0, 0, 0, "giay_wrap_dn");

        set_sel = 1'b1;
        for (int i = 0; i < 6; i++)
            step(1, 0, 1, 1, phut_seq[i], 8'h59, 0, 0, 0, "phut_dec");
        step(0, 1, 1, 1, 8'h00, 8'h59, 0, 0, 0, "phut_wrap_up");

        set_sel = 1'b0;
        step(0, 1, 1, 1, 8'h00, 8'h00, 0, 0, 0, "giay_wrap_up");
        step(1, 1, 0, 1, 8'h00, 8'h00, 0, 0, 0, "start_at_zero");
        step(0, 1, 1, 1, 8'h00, 8'h01, 0, 0, 0, "load1");
        step(0, 1, 1, 1, 8'h00, 8'h02, 0, 0, 0, "load2");
        step(0, 1, 1, 1, 8'h00, 8'h03, 0, 0, 0, "load3");
        step(1, 1, 0, 1, 8'h00, 8'h03, 1, 0, 0, "start_run");
        step(1, 1, 1, 1, 8'h00, 8'h02, 1, 0, 0, "run_02");
        step(1, 1, 1, 1, 8'h00, 8'h01, 1, 0, 0, "run_01");
        step(1, 1, 1, 1, 8'h00, 8'h00, 0, 1, 1, "run_done");
        for (int i = 0; i < 9; i++)
            step(1, 1, 1, 1, 8'h00, 8'h00, 0, 1, 1, "beep_hold");
        step(1, 1, 1, 1, 8'h00, 8'h00, 0, 1, 0, "beep_off");
        step(1, 1, 1, 1, 8'h00, 8'h00, 0, 1, 0, "done_hold");
        step(1, 1, 0, 1, 8'h00, 8'h03, 0, 0, 0, "done_ack");
        step(1, 1, 1, 1, 8'h00, 8'h03, 0, 0, 0, "set_idle");

        set_sel = 1'b1;
        step(0, 1, 1, 1, 8'h01, 8'h03, 0, 0, 0, "phut_inc");
        set_sel = 1'b0;
        step(1, 0, 1, 1, 8'h01, 8'h02, 0, 0, 0, "giay_dec_a");
        step(1, 0, 1, 1, 8'h01, 8'h01, 0, 0, 0, "giay_dec_b");
        step(1, 0, 1, 1, 8'h01, 8'h00, 0, 0, 0, "giay_dec_c");
        step(1, 1, 0, 1, 8'h01, 8'h00, 1, 0, 0, "start_100");
        step(1, 1, 1, 1, 8'h00, 8'h59, 1, 0, 0, "borrow_phut");
        step(1, 1, 0, 1, 8'h00, 8'h59, 0, 0, 0, "pause");
        step(1, 1, 1, 1, 8'h00, 8'h59, 0, 0, 0, "pause_hold");
        step(0, 1, 1, 1, 8'h00, 8'h59, 0, 0, 0, "pause_up_ign");
        step(1, 0, 1, 1, 8'h00, 8'h59, 0, 0, 0, "pause_dn_ign");
        step(1, 1, 1, 1, 8'h00, 8'h59, 0, 0, 0, "pause_hold");
        step(1, 1, 1, 1, 8'h00, 8'h59, 0, 0, 0, "pause_hold");
        step(1, 1, 0, 1, 8'h00, 8'h59, 1, 0, 0, "resume");
        step(0, 1, 1, 1, 8'h00, 8'h58, 1, 0, 0, "resume_dec");
        for (int s = 57; s >= 40; s--) begin
            g = {4'(s / 10), 4'(s % 10)};
            step(1, 1, 1, 1, 8'h00, g, 1, 0, 0, "run_down");
        end
        step(1, 1, 0, 0, 8'h01, 8'h00, 0, 0, 0, "clr_over_start");
        step(1, 1, 1, 1, 8'h01, 8'h00, 0, 0, 0, "after_clr");
        step(1, 1, 0, 1, 8'h01, 8'h00, 1, 0, 0, "restart");
        step(1, 1, 1, 1, 8'h00, 8'h59, 1, 0, 0, "restart_dec");

        #2 rst_n = 1'b0;
        #1;
        sb.push_back('{p: 8'h05, g: 8'h00, r: 1'b0, d: 1'b0, b: 1'b0});
        check_out("async_reset");
        @(posedge clk_1Hz);
        #1 rst_n = 1'b1;
        step(1, 1, 1, 1, 8'h05, 8'h00, 0, 0, 0, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
